// File: rtl/acquire_beat_queue_if.sv
// Acquire beat bus between the upstream arbiter, the beat queue and its consumer.
// The master drives enqueue beats and deq_ready; the slave (the queue) drives the rest.
`timescale 1ns/1ps
interface acquire_beat_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   // Enqueue side
   logic             io_enq_valid;
   logic             io_enq_ready;
   logic [25:0]      io_enq_bits_addr_block;
   logic [1:0]       io_enq_bits_client_xact_id;
   logic [2:0]       io_enq_bits_addr_beat;
   logic             io_enq_bits_is_builtin_type;
   logic [2:0]       io_enq_bits_a_type;
   logic [11:0]      io_enq_bits_union;
   logic [63:0]      io_enq_bits_data;
   logic             io_enq_chosen;

   // Dequeue side
   logic             io_deq_valid;
   logic             io_deq_ready;
   logic [25:0]      io_deq_bits_addr_block;
   logic [1:0]       io_deq_bits_client_xact_id;
   logic [2:0]       io_deq_bits_addr_beat;
   logic             io_deq_bits_is_builtin_type;
   logic [2:0]       io_deq_bits_a_type;
   logic [11:0]      io_deq_bits_union;
   logic [63:0]      io_deq_bits_data;
   logic             io_deq_source;
   logic             io_deq_last;

   // Status
   logic [CNT_W-1:0] io_count;
   logic             io_burst_error;

   modport master (
      output io_enq_valid, io_enq_bits_addr_block, io_enq_bits_client_xact_id,
             io_enq_bits_addr_beat, io_enq_bits_is_builtin_type, io_enq_bits_a_type,
             io_enq_bits_union, io_enq_bits_data, io_enq_chosen, io_deq_ready,
      input  io_enq_ready, io_deq_valid, io_deq_bits_addr_block, io_deq_bits_client_xact_id,
             io_deq_bits_addr_beat, io_deq_bits_is_builtin_type, io_deq_bits_a_type,
             io_deq_bits_union, io_deq_bits_data, io_deq_source, io_deq_last,
             io_count, io_burst_error
   );

   modport slave (
      input  io_enq_valid, io_enq_bits_addr_block, io_enq_bits_client_xact_id,
             io_enq_bits_addr_beat, io_enq_bits_is_builtin_type, io_enq_bits_a_type,
             io_enq_bits_union, io_enq_bits_data, io_enq_chosen, io_deq_ready,
      output io_enq_ready, io_deq_valid, io_deq_bits_addr_block, io_deq_bits_client_xact_id,
             io_deq_bits_addr_beat, io_deq_bits_is_builtin_type, io_deq_bits_a_type,
             io_deq_bits_union, io_deq_bits_data, io_deq_source, io_deq_last,
             io_count, io_burst_error
   );
endinterface

// File: rtl/acquire_beat_queue.sv
// Ring-buffer queue for Acquire beats with no bypass, plus a sticky checker that
// flags malformed put-block bursts as they are enqueued.
`timescale 1ns/1ps
module acquire_beat_queue #(
   parameter int unsigned DEPTH = 4
) (
   input logic               clk,
   input logic               reset,
   acquire_beat_queue_if.slave q
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [2:0]  PUT_BLOCK = 3'h3;
   localparam logic [2:0]  LAST_BEAT = 3'h7;

   typedef struct packed {
      logic [25:0] addr_block;
      logic [1:0]  client_xact_id;
      logic [2:0]  addr_beat;
      logic        is_builtin_type;
      logic [2:0]  a_type;
      logic [11:0] union_bits;
      logic [63:0] data;
      logic        source;
   } entry_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } burst_state_e;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   burst_state_e     state_q, state_d;
   logic [2:0]       expected_q, expected_d;
   logic             burst_src_q, burst_src_d;
   logic             error_q, error_d;

   logic             enq_ready_c;
   logic             deq_valid_c;
   logic             enq_fire_c;
   logic             deq_fire_c;
   logic             enq_put_block_c;
   logic             head_put_block_c;
   entry_t           enq_entry_c;
   entry_t           head_c;

   // Handshake flags depend only on the registered occupancy.
   assign enq_ready_c = (count != CNT_W'(DEPTH));
   assign deq_valid_c = (count != CNT_W'(0));
   assign enq_fire_c  = q.io_enq_valid & enq_ready_c;
   assign deq_fire_c  = q.io_deq_ready & deq_valid_c;

   assign enq_entry_c.addr_block      = q.io_enq_bits_addr_block;
   assign enq_entry_c.client_xact_id  = q.io_enq_bits_client_xact_id;
   assign enq_entry_c.addr_beat       = q.io_enq_bits_addr_beat;
   assign enq_entry_c.is_builtin_type = q.io_enq_bits_is_builtin_type;
   assign enq_entry_c.a_type          = q.io_enq_bits_a_type;
   assign enq_entry_c.union_bits      = q.io_enq_bits_union;
   assign enq_entry_c.data            = q.io_enq_bits_data;
   assign enq_entry_c.source          = q.io_enq_chosen;

   assign enq_put_block_c = q.io_enq_bits_is_builtin_type &
                            (q.io_enq_bits_a_type == PUT_BLOCK);

   // Storage is intentionally left out of reset; only pointers and count clear.
   always_ff @(posedge clk) begin
      if (enq_fire_c) begin
         mem[wr_ptr] <= enq_entry_c;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_fire_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (deq_fire_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (enq_fire_c && !deq_fire_c) begin
            count <= count + CNT_W'(1);
         end else if (!enq_fire_c && deq_fire_c) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Burst checker state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         expected_q  <= 3'h0;
         burst_src_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         burst_src_q <= burst_src_d;
         error_q     <= error_d;
      end
   end

   // Burst checker next state; only enqueue fires advance it.
   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      burst_src_d = burst_src_q;
      error_d     = error_q;
      if (enq_fire_c) begin
         unique case (state_q)
            ST_IDLE: begin
               if (enq_put_block_c) begin
                  state_d     = ST_BURST;
                  expected_d  = 3'h1;
                  burst_src_d = q.io_enq_chosen;
                  if (q.io_enq_bits_addr_beat != 3'h0) begin
                     error_d = 1'b1;
                  end
               end
            end
            ST_BURST: begin
               if (!enq_put_block_c ||
                   (q.io_enq_chosen != burst_src_q) ||
                   (q.io_enq_bits_addr_beat != expected_q)) begin
                  error_d = 1'b1;
               end
               // 7 + 1 wraps to 0, which is the idle expectation.
               expected_d = expected_q + 3'h1;
               if (expected_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign head_c           = mem[rd_ptr];
   assign head_put_block_c = head_c.is_builtin_type & (head_c.a_type == PUT_BLOCK);

   assign q.io_enq_ready                = enq_ready_c;
   assign q.io_deq_valid                = deq_valid_c;
   assign q.io_deq_bits_addr_block      = head_c.addr_block;
   assign q.io_deq_bits_client_xact_id  = head_c.client_xact_id;
   assign q.io_deq_bits_addr_beat       = head_c.addr_beat;
   assign q.io_deq_bits_is_builtin_type = head_c.is_builtin_type;
   assign q.io_deq_bits_a_type          = head_c.a_type;
   assign q.io_deq_bits_union           = head_c.union_bits;
   assign q.io_deq_bits_data            = head_c.data;
   assign q.io_deq_source               = head_c.source;
   assign q.io_deq_last                 = !head_put_block_c || (head_c.addr_beat == LAST_BEAT);
   assign q.io_count                    = count;
   assign q.io_burst_error              = error_q;

endmodule

// File: tb/tb_acquire_beat_queue.sv
// Self-checking bench for acquire_beat_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_acquire_beat_queue;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [25:0] addr_block;
      logic [1:0]  xid;
      logic [2:0]  ab;
      logic        bi;
      logic [2:0]  at;
      logic [11:0] un;
      logic [63:0] data;
      logic        src;
   } beat_t;

   typedef struct {
      bit          ev;
      bit          dr;
      logic [63:0] data;
      int          ecount;
      bit          eready;
      bit          evalid;
      logic [63:0] edata;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   acquire_beat_queue_if #(.DEPTH(DEPTH)) bus ();
   acquire_beat_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(bus));

   int total = 0;
   int bad   = 0;

   beat_t mq[$];
   bit    m_in_burst;
   int    m_exp;
   bit    m_src;
   bit    m_err;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t dut_head();
      beat_t b;
      b.addr_block = bus.io_deq_bits_addr_block;
      b.xid        = bus.io_deq_bits_client_xact_id;
      b.ab         = bus.io_deq_bits_addr_beat;
      b.bi         = bus.io_deq_bits_is_builtin_type;
      b.at         = bus.io_deq_bits_a_type;
      b.un         = bus.io_deq_bits_union;
      b.data       = bus.io_deq_bits_data;
      b.src        = bus.io_deq_source;
      return b;
   endfunction

   function automatic beat_t mk(input bit bi, input logic [2:0] at, input logic [2:0] ab,
                                input bit src, input logic [63:0] data);
      beat_t b;
      b.addr_block = 26'h0123456 ^ data[25:0];
      b.xid        = ab[1:0];
      b.ab         = ab;
      b.bi         = bi;
      b.at         = at;
      b.un         = 12'hA5C ^ data[11:0];
      b.data       = data;
      b.src        = src;
      return b;
   endfunction

   function automatic bit is_pb(input beat_t b);
      return b.bi && (b.at == 3'h3);
   endfunction

   function automatic bit exp_last(input beat_t b);
      return !is_pb(b) || (b.ab == 3'h7);
   endfunction

   task automatic set_inputs(input bit ev, input beat_t b, input bit dr);
      bus.io_enq_valid                = ev;
      bus.io_enq_bits_addr_block      = b.addr_block;
      bus.io_enq_bits_client_xact_id  = b.xid;
      bus.io_enq_bits_addr_beat       = b.ab;
      bus.io_enq_bits_is_builtin_type = b.bi;
      bus.io_enq_bits_a_type          = b.at;
      bus.io_enq_bits_union           = b.un;
      bus.io_enq_bits_data            = b.data;
      bus.io_enq_chosen               = b.src;
      bus.io_deq_ready                = dr;
   endtask

   task automatic model_reset();
      mq.delete();
      m_in_burst = 0;
      m_exp      = 0;
      m_src      = 0;
      m_err      = 0;
   endtask

   // Burst rule: a put-block message is 8 beats numbered 0..7 from one source.
   task automatic model_enq(input beat_t b);
      mq.push_back(b);
      if (!m_in_burst) begin
         if (is_pb(b)) begin
            m_in_burst = 1;
            m_exp      = 1;
            m_src      = b.src;
            if (b.ab != 3'h0) m_err = 1;
         end
      end else begin
         if (!is_pb(b) || (b.src != m_src) || (int'(b.ab) != m_exp)) m_err = 1;
         if (m_exp == 7) begin
            m_in_burst = 0;
            m_exp      = 0;
         end else begin
            m_exp++;
         end
      end
   endtask

   // One clock: drive, check against the model, clock, update the model.
   task automatic cycle(input bit ev, input beat_t b, input bit dr);
      bit ef;
      bit df;
      set_inputs(ev, b, dr);
      #1;
      chk("count", 128'(bus.io_count), 128'(mq.size()));
      chk("enq_ready", 128'(bus.io_enq_ready), 128'(mq.size() != DEPTH));
      chk("deq_valid", 128'(bus.io_deq_valid), 128'(mq.size() != 0));
      chk("burst_error", 128'(bus.io_burst_error), 128'(m_err));
      if (mq.size() != 0) begin
         chk("head", 128'(dut_head()), 128'(mq[0]));
         chk("last", 128'(bus.io_deq_last), 128'(exp_last(mq[0])));
      end
      ef = ev && (mq.size() != DEPTH);
      df = dr && (mq.size() != 0);
      @(posedge clk);
      if (df) void'(mq.pop_front());
      if (ef) model_enq(b);
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_inputs(1'b0, beat_t'('0), 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   vec_t  vt[10];
   beat_t nb;

   initial begin
      // Fill four plain beats, try a fifth while full, then drain in order.
      vt[0] = '{1, 0, 64'h11, 0, 1, 0, 64'h0};
      vt[1] = '{1, 0, 64'h22, 1, 1, 1, 64'h11};
      vt[2] = '{1, 0, 64'h33, 2, 1, 1, 64'h11};
      vt[3] = '{1, 0, 64'h44, 3, 1, 1, 64'h11};
      vt[4] = '{1, 0, 64'h55, 4, 0, 1, 64'h11};
      vt[5] = '{0, 1, 64'h00, 4, 0, 1, 64'h11};
      vt[6] = '{0, 1, 64'h00, 3, 1, 1, 64'h22};
      vt[7] = '{0, 1, 64'h00, 2, 1, 1, 64'h33};
      vt[8] = '{0, 1, 64'h00, 1, 1, 1, 64'h44};
      vt[9] = '{0, 0, 64'h00, 0, 1, 0, 64'h0};

      set_inputs(1'b0, beat_t'('0), 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_count", 128'(bus.io_count), 128'(0));
      chk("rst_enq_ready", 128'(bus.io_enq_ready), 128'(1));
      chk("rst_deq_valid", 128'(bus.io_deq_valid), 128'(0));
      chk("rst_error", 128'(bus.io_burst_error), 128'(0));
      reset = 1'b1;
      model_reset();

      foreach (vt[i]) begin
         set_inputs(vt[i].ev, mk(1'b0, 3'h0, 3'h0, 1'b0, vt[i].data), vt[i].dr);
         #1;
         chk($sformatf("vec%0d_count", i), 128'(bus.io_count), 128'(vt[i].ecount));
         chk($sformatf("vec%0d_ready", i), 128'(bus.io_enq_ready), 128'(vt[i].eready));
         chk($sformatf("vec%0d_valid", i), 128'(bus.io_deq_valid), 128'(vt[i].evalid));
         if (vt[i].evalid) begin
            chk($sformatf("vec%0d_data", i), 128'(bus.io_deq_bits_data), 128'(vt[i].edata));
            chk($sformatf("vec%0d_last", i), 128'(bus.io_deq_last), 128'(1));
         end
         @(posedge clk);
         @(negedge clk);
      end

      // Full queue with simultaneous enq/deq: only the dequeue fires.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, mk(1'b0, 3'h1, 3'h0, 1'b0, 64'(i + 1)), 1'b0);
      cycle(1'b1, mk(1'b0, 3'h1, 3'h0, 1'b1, 64'h99), 1'b1);
      #1;
      chk("full_both_count", 128'(bus.io_count), 128'(3));
      chk("full_both_ready", 128'(bus.io_enq_ready), 128'(1));

      // Clean 8-beat put-block burst from source 1, interleaved with dequeues.
      do_reset();
      for (int b = 0; b < 8; b++) begin
         cycle(1'b1, mk(1'b1, 3'h3, 3'(b), 1'b1, 64'(32'hB000 + b)), 1'b0);
         #1;
         chk($sformatf("burst_last_b%0d", b), 128'(bus.io_deq_last), 128'(b == 7));
         cycle(1'b0, beat_t'('0), 1'b1);
      end
      #1;
      chk("burst_clean_error", 128'(bus.io_burst_error), 128'(0));

      // Beat gap 0,1,3 raises the sticky error.
      do_reset();
      cycle(1'b1, mk(1'b1, 3'h3, 3'h0, 1'b0, 64'hC0), 1'b0);
      cycle(1'b1, mk(1'b1, 3'h3, 3'h1, 1'b0, 64'hC1), 1'b0);
      #1;
      chk("gap_err_before", 128'(bus.io_burst_error), 128'(0));
      cycle(1'b1, mk(1'b1, 3'h3, 3'h3, 1'b0, 64'hC3), 1'b0);
      #1;
      chk("gap_err_after", 128'(bus.io_burst_error), 128'(1));
      for (int i = 0; i < 5; i++) cycle(1'b0, beat_t'('0), 1'b1);
      #1;
      chk("gap_err_sticky", 128'(bus.io_burst_error), 128'(1));

      // Source switch mid-burst: error, but both beats still delivered.
      do_reset();
      cycle(1'b1, mk(1'b1, 3'h3, 3'h0, 1'b0, 64'hD0), 1'b0);
      cycle(1'b1, mk(1'b1, 3'h3, 3'h1, 1'b1, 64'hD1), 1'b0);
      #1;
      chk("src_err", 128'(bus.io_burst_error), 128'(1));
      chk("src_first", 128'(bus.io_deq_source), 128'(0));
      cycle(1'b0, beat_t'('0), 1'b1);
      #1;
      chk("src_second", 128'(bus.io_deq_source), 128'(1));
      cycle(1'b0, beat_t'('0), 1'b1);

      // Asynchronous reset mid-burst with three beats queued.
      do_reset();
      for (int b = 0; b < 3; b++) cycle(1'b1, mk(1'b1, 3'h3, 3'(b), 1'b1, 64'(b)), 1'b0);
      set_inputs(1'b0, beat_t'('0), 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("async_count", 128'(bus.io_count), 128'(0));
      chk("async_valid", 128'(bus.io_deq_valid), 128'(0));
      chk("async_ready", 128'(bus.io_enq_ready), 128'(1));
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      cycle(1'b1, mk(1'b1, 3'h3, 3'h0, 1'b0, 64'hE0), 1'b0);
      #1;
      chk("post_rst_count", 128'(bus.io_count), 128'(1));
      chk("post_rst_error", 128'(bus.io_burst_error), 128'(0));

      // Randomized traffic; the last phase injects burst corruptions.
      for (int ph = 0; ph < 4; ph++) begin
         logic [2:0] gab;
         bit         gsrc;
         bit         ev;
         bit         dr;
         do_reset();
         gab  = 3'h0;
         gsrc = 1'($urandom);
         for (int c = 0; c < 200; c++) begin
            ev = ($urandom_range(0, 99) < 60);
            dr = ($urandom_range(0, 99) < (30 + 20 * ph));
            if ((gab == 3'h0) && ($urandom_range(0, 99) < 30)) begin
               nb = mk(1'b0, 3'($urandom), 3'($urandom), 1'($urandom), {$urandom, $urandom});
            end else begin
               nb = mk(1'b1, 3'h3, gab, gsrc, {$urandom, $urandom});
               if ((ph == 3) && ($urandom_range(0, 99) < 5)) nb.ab = 3'($urandom);
               if ((ph == 3) && ($urandom_range(0, 99) < 5)) nb.src = ~gsrc;
               if (ev && (mq.size() != DEPTH)) begin
                  gab = gab + 3'h1;
                  if (gab == 3'h0) gsrc = 1'($urandom);
               end
            end
            cycle(ev, nb, dr);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acquire_beat_queue.md
ACQUIRE_BEAT_QUEUE -- requirements
Module: acquire_beat_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered beats; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; all state SHALL clear immediately when reset is low.
REQ-004 io_enq_valid  input  1  arbiter output beat valid.
REQ-005 io_enq_ready  output  1  queue accepts beat.
REQ-006 io_enq_bits_addr_block 26, client_xact_id 2, addr_beat 3, is_builtin_type 1, a_type 3, union 12, data 64  inputs  Acquire beat fields from the upstream arbiter.
REQ-007 io_enq_chosen  input  1  arbiter grant index for this beat.
REQ-008 io_deq_valid  output  1  head entry present.
REQ-009 io_deq_ready  input  1  consumer accepts head.
REQ-010 io_deq_bits_* (same seven fields and widths as REQ-006) and io_deq_source (1)  outputs  head entry contents.
REQ-011 io_deq_last  output  1  head is a single-beat message or the final put-block beat.
REQ-012 io_count  output  clog2(DEPTH+1)  occupied entries.
REQ-013 io_burst_error  output  1  sticky burst-protocol violation flag.

Function
REQ-014 Enqueue fires when io_enq_valid and io_enq_ready are both 1; dequeue fires when io_deq_valid and io_deq_ready are both 1.
REQ-015 Storage SHALL be a DEPTH-entry ring buffer with write and read pointers wrapping modulo DEPTH.
REQ-016 io_enq_ready SHALL equal (count != DEPTH); io_deq_valid SHALL equal (count != 0); both are functions of registered state only.
REQ-017 No bypass: a beat enqueued in cycle N SHALL first appear at the deq port in cycle N+1.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-019 When full, a dequeue in cycle N SHALL raise io_enq_ready in cycle N+1, not in cycle N.
REQ-020 Entries SHALL be delivered strictly in enqueue order with all fields unmodified; io_deq_source SHALL equal the stored io_enq_chosen.
REQ-021 Put-block beat: is_builtin_type == 1 and a_type == 3'h3.
REQ-022 io_deq_last SHALL be 1 when the head is not a put-block beat, or is a put-block beat with addr_beat == 3'h7; otherwise 0.
REQ-023 Burst checker state machine on enqueue side: IDLE and BURST, with a 3-bit expected-beat register and a 1-bit burst-source register.
REQ-024 IDLE, enqueue of non-put-block beat: remain IDLE.
REQ-025 IDLE, enqueue of put-block beat: go BURST, expected = 1, latch source; set error if addr_beat != 0.
REQ-026 BURST, enqueue of any beat: set error if it is not put-block, source differs from latched, or addr_beat != expected; expected increments.
REQ-027 BURST, enqueue when expected == 7: return to IDLE regardless of error.
REQ-028 Violating beats SHALL still be enqueued; io_burst_error SHALL remain 1 until reset.
REQ-029 Dequeue activity SHALL not affect the burst checker.

Reset
REQ-030 During and after reset: count 0, pointers 0, checker IDLE, expected 0, io_burst_error 0, io_deq_valid 0, io_enq_ready 1; storage contents are not reset.
REQ-031 Reset asserted mid-burst SHALL discard all queued beats and return the checker to IDLE.

Verification
REQ-032 Fill DEPTH=4 with deq_ready 0, data 0x11..0x44 -> io_count 4, io_enq_ready 0; then drain -> data 0x11,0x22,0x33,0x44 in order.
REQ-033 Full queue, enq_valid and deq_ready both 1 for one cycle -> only dequeue fires, count 3, io_enq_ready 1 next cycle.
REQ-034 Eight put-block beats source 1, addr_beat 0..7, interleaved with deq -> io_burst_error 0, io_deq_last 1 only on beat 7.
REQ-035 Put-block beats 0,1,3 -> io_burst_error rises the cycle after beat 3 is accepted and stays 1.
REQ-036 Put-block beat 0 from source 0 then beat 1 from source 1 -> io_burst_error 1; both beats dequeued with io_deq_source 0 then 1.
REQ-037 Reset low with 3 entries queued mid-burst -> io_count 0, io_deq_valid 0 immediately; new beat 0 after release accepted with no error.
